// File: rtl/core_mem_wb_bridge_if.sv
// Signal bundle between a core memory port and a Wishbone B4 master.
// "master" is the bridge's view; "slave" is the view of the core and the Wishbone slave.
interface core_mem_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic                  core_req_i;
  logic                  core_we_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic [SEL_WIDTH-1:0]  core_be_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;
  logic                  core_err_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_stall_i;

  modport master (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/core_mem_wb_bridge.sv
// Core valid/grant memory port to Wishbone B4 master: one outstanding transaction,
// classic or pipelined, with bus-error/timeout reporting and a registered response.
module core_mem_wb_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PIPELINED      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  sys_clk,
  input logic                  rst_n,
  core_mem_wb_bridge_if.master bus
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [15:0]           r_cnt;

  logic w_gnt;
  logic w_accept;
  logic w_resp_ok;
  logic w_timeout;
  logic w_done;
  logic w_to_wait;

  assign w_gnt     = rst_n && (r_state == S_IDLE) && bus.core_req_i;
  // Classic slaves never stall; pipelined slaves only see the request once stall is low.
  assign w_accept  = (PIPELINED == 0) || !bus.wb_stall_i;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_resp_ok = (bus.wb_ack_i || bus.wb_err_i) &&
                     ((r_state == S_WAIT) || ((r_state == S_REQ) && w_accept));

  always_comb begin
    w_done    = 1'b0;
    w_to_wait = 1'b0;
    case (r_state)
      S_REQ: begin
        if (w_resp_ok || w_timeout) w_done = 1'b1;
        else if (w_accept && (PIPELINED != 0)) w_to_wait = 1'b1;
      end
      S_WAIT: begin
        if (w_resp_ok || w_timeout) w_done = 1'b1;
      end
      default: begin
        w_done    = 1'b0;
        w_to_wait = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_we    <= bus.core_we_i;
            r_sel   <= bus.core_be_i;
            r_adr   <= bus.core_addr_i;
            r_dat   <= bus.core_wdata_i;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_done) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
            r_rvalid <= 1'b1;
            // A real response beats a coincident timeout; err beats ack.
            r_err    <= w_resp_ok ? bus.wb_err_i : 1'b1;
            r_rdata  <= (w_resp_ok && !bus.wb_err_i && !r_we) ? bus.wb_dat_i : '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (w_to_wait) begin
              r_stb   <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.core_gnt_o    = w_gnt;
  assign bus.core_rvalid_o = r_rvalid;
  assign bus.core_rdata_o  = r_rdata;
  assign bus.core_err_o    = r_err;
  assign bus.wb_cyc_o      = r_cyc;
  assign bus.wb_stb_o      = r_stb;
  assign bus.wb_we_o       = r_we;
  assign bus.wb_sel_o      = r_sel;
  assign bus.wb_adr_o      = r_adr;
  assign bus.wb_dat_o      = r_dat;
endmodule
